// File: rtl/fft_iter_sched_if.sv
// Handshake and bus bundle between the FFT scheduler and its environment.
interface fft_iter_sched_if #(
  parameter int MAX_LOG2N = 10
);
  logic                   i_CFG_VALID;
  logic [3:0]             i_CFG_LOG2N;
  logic                   o_CFG_READY;
  logic                   o_CFG_ERR;
  logic                   o_PARAM_EN;
  logic [3:0]             o_LOG2N;
  logic                   i_START;
  logic                   i_ABORT;
  logic                   o_BUSY;
  logic                   o_RD_VALID;
  logic [MAX_LOG2N-1:0]   o_RD_ADDR_A;
  logic [MAX_LOG2N-1:0]   o_RD_ADDR_B;
  logic [MAX_LOG2N-2:0]   o_TW_IDX;
  logic [3:0]             o_STAGE;
  logic                   o_WR_EN;
  logic [MAX_LOG2N-1:0]   o_WR_ADDR_A;
  logic [MAX_LOG2N-1:0]   o_WR_ADDR_B;
  logic                   o_DONE;

  modport master (
    output i_CFG_VALID, i_CFG_LOG2N, i_START, i_ABORT,
    input  o_CFG_READY, o_CFG_ERR, o_PARAM_EN, o_LOG2N, o_BUSY, o_RD_VALID,
           o_RD_ADDR_A, o_RD_ADDR_B, o_TW_IDX, o_STAGE, o_WR_EN,
           o_WR_ADDR_A, o_WR_ADDR_B, o_DONE
  );

  modport slave (
    input  i_CFG_VALID, i_CFG_LOG2N, i_START, i_ABORT,
    output o_CFG_READY, o_CFG_ERR, o_PARAM_EN, o_LOG2N, o_BUSY, o_RD_VALID,
           o_RD_ADDR_A, o_RD_ADDR_B, o_TW_IDX, o_STAGE, o_WR_EN,
           o_WR_ADDR_A, o_WR_ADDR_B, o_DONE
  );
endinterface

// File: rtl/fft_iter_sched.sv
// Stage/butterfly scheduler for an iterative radix-2 DIT FFT core.
// Issues one butterfly per cycle, mirrors the issue stream onto a delayed
// write-back port and inserts a PIPE_LAT drain gap between stages.
module fft_iter_sched #(
  parameter int MAX_LOG2N = 10,
  parameter int PIPE_LAT  = 4
) (
  input  logic            CLK,
  input  logic            RST,
  fft_iter_sched_if.slave bus
);
  localparam int AW  = MAX_LOG2N;
  localparam int TWW = MAX_LOG2N - 1;
  localparam int CW  = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state;
  logic [3:0]      log2n;
  logic [3:0]      stage;
  logic [TWW-1:0]  bidx;
  logic [CW-1:0]   cnt;
  logic            cfg_err, param_en, busy, rd_valid, done;
  logic [AW-1:0]   rd_a, rd_b;
  logic [TWW-1:0]  tw;
  logic [PIPE_LAT-1:0] wv;
  logic [AW-1:0]   wa [PIPE_LAT];
  logic [AW-1:0]   wb [PIPE_LAT];

  logic [3:0]      iss_s;
  logic [TWW-1:0]  iss_b;
  logic [AW-1:0]   bx, span, pos, a_n, b_n;
  logic [TWW-1:0]  tw_n, last_b;
  logic            cfg_take, cfg_ok;

  assign cfg_take = bus.i_CFG_VALID && (state == IDLE);
  assign cfg_ok   = (bus.i_CFG_LOG2N != 4'd0) && (bus.i_CFG_LOG2N <= 4'(MAX_LOG2N));
  // wraps to all-ones when N/2 equals 2^TWW, which is still the correct last index
  assign last_b   = (TWW'(1) << (log2n - 4'd1)) - TWW'(1);

  // Addresses of the butterfly that will be issued on the next cycle
  always_comb begin
    iss_s = '0;
    iss_b = '0;
    case (state)
      RUN:     begin iss_s = stage;        iss_b = bidx + TWW'(1); end
      DRAIN:   begin iss_s = stage + 4'd1; iss_b = '0;             end
      default: begin iss_s = '0;           iss_b = '0;             end
    endcase
    bx   = {1'b0, iss_b};
    span = AW'(1) << iss_s;
    pos  = bx & (span - AW'(1));
    a_n  = ((bx >> iss_s) << (iss_s + 4'd1)) | pos;
    b_n  = a_n | span;
    tw_n = TWW'(pos << (log2n - 4'd1 - iss_s));
  end

  // Control FSM, issue registers and write-back delay line
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      log2n    <= 4'(MAX_LOG2N);
      stage    <= '0;
      bidx     <= '0;
      cnt      <= '0;
      cfg_err  <= 1'b0;
      param_en <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      rd_a     <= '0;
      rd_b     <= '0;
      tw       <= '0;
      wv       <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        wa[i] <= '0;
        wb[i] <= '0;
      end
    end else begin
      cfg_err  <= 1'b0;
      param_en <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      wv[0]    <= rd_valid;
      wa[0]    <= rd_a;
      wb[0]    <= rd_b;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        wv[i] <= wv[i-1];
        wa[i] <= wa[i-1];
        wb[i] <= wb[i-1];
      end
      if (bus.i_ABORT && state != IDLE) begin
        // later assignment overrides the shift above, flushing pending writes
        state <= IDLE;
        busy  <= 1'b0;
        wv    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_take) begin
              if (cfg_ok) begin
                log2n    <= bus.i_CFG_LOG2N;
                param_en <= 1'b1;
              end else begin
                cfg_err <= 1'b1;
              end
            end
            if (bus.i_START) begin
              state    <= RUN;
              busy     <= 1'b1;
              stage    <= '0;
              bidx     <= '0;
              rd_valid <= 1'b1;
              rd_a     <= a_n;
              rd_b     <= b_n;
              tw       <= tw_n;
            end
          end
          RUN: begin
            if (bidx == last_b) begin
              state <= DRAIN;
              cnt   <= CW'(PIPE_LAT - 1);
            end else begin
              bidx     <= iss_b;
              rd_valid <= 1'b1;
              rd_a     <= a_n;
              rd_b     <= b_n;
              tw       <= tw_n;
            end
          end
          DRAIN: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (stage == log2n - 4'd1) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= RUN;
              stage    <= iss_s;
              bidx     <= '0;
              rd_valid <= 1'b1;
              rd_a     <= a_n;
              rd_b     <= b_n;
              tw       <= tw_n;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_CFG_READY = (state == IDLE);
  assign bus.o_CFG_ERR   = cfg_err;
  assign bus.o_PARAM_EN  = param_en;
  assign bus.o_LOG2N     = log2n;
  assign bus.o_BUSY      = busy;
  assign bus.o_RD_VALID  = rd_valid;
  assign bus.o_RD_ADDR_A = rd_a;
  assign bus.o_RD_ADDR_B = rd_b;
  assign bus.o_TW_IDX    = tw;
  assign bus.o_STAGE     = stage;
  assign bus.o_WR_EN     = wv[PIPE_LAT-1];
  assign bus.o_WR_ADDR_A = wa[PIPE_LAT-1];
  assign bus.o_WR_ADDR_B = wb[PIPE_LAT-1];
  assign bus.o_DONE      = done;
endmodule
